vq_decoder: RTL
===============

Name: vq_decoder

Overview:
- Inverse of the vector-quantization encoder: takes one codebook index and streams the reconstructed DIM-element Q16.16 vector, one element per handshake.
- Holds a writable codebook. Software or a loader fills it through a simple write port, using the same codebook contents the encoder uses.
- Sits downstream of the index channel and feeds the reconstruction or dequantized datapath.

Parameters:
- DIM, 8, elements per vector.
- NUM_CODES, 16, codebook entries. Must be a power of two.
- DATA_W, 32, element width, Q16.16 two's complement.
- IDX_W, $clog2(NUM_CODES), index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cb_we_i  in  1  codebook write strobe.
- cb_addr_i  in  IDX_W+$clog2(DIM)  write address, {code, element}.
- cb_data_i  in  DATA_W  write data.
- start_i  in  1  single-cycle decode request. Sampled only in IDLE.
- idx_i  in  IDX_W  code index. Captured with start_i.
- busy_o  out  1  decode in progress.
- valid_o  out  1  dout_o holds a valid element.
- ready_i  in  1  downstream accepts the element.
- dout_o  out  DATA_W  reconstructed element.
- elem_o  out  $clog2(DIM)  element number of dout_o.
- last_o  out  1  dout_o is element DIM-1.
- done_o  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (asynchronous, active-high rst_i):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Codebook contents are not reset (RAM).
  - Reset asserted mid-decode aborts the decode immediately. No done_o is produced.
- Codebook RAM:
  - Synchronous write: a write at edge T is readable from edge T+1.
  - Synchronous read, 1-cycle latency.
  - cb_we_i is ignored while busy_o=1; the entry stays unchanged.
  - A write and a start in the same IDLE cycle: the write commits and the decode starts. The element addressed by the write returns the new data.
- Handshake: an element transfers on a cycle where valid_o=1 and ready_i=1.
  - While valid_o=1 and ready_i=0, dout_o, elem_o and last_o hold stable.
  - valid_o never drops before its transfer.
- FSM states: IDLE, FETCH, STREAM, DONE.
  - IDLE: when start_i=1, latch idx_i, issue a read of {idx, 0}, set busy_o=1, go to FETCH. start_i in any other state is ignored.
  - FETCH: RAM data is registered into dout_o, valid_o=1, elem_o=0, read of element 1 issued, go to STREAM.
  - STREAM: on each transfer, load the prefetched next element. The element count increments on transfer only. On the transfer of elem_o=DIM-1 (last_o=1): valid_o=0, go to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, go to IDLE. A new start_i is accepted in the following cycle.
- Prefetch: the RAM read for element k+1 is issued so the element can be presented the cycle after element k transfers.
  - A one-entry holding register absorbs the RAM output under backpressure.
  - There are no bubbles when ready_i=1.
- Latency with ready_i held 1 and start at edge T:
  - busy_o from T+1.
  - Elements 0..DIM-1 valid at T+2..T+DIM+1, one per cycle.
  - done_o at T+DIM+2.
  - busy_o low at T+DIM+2.
- Arithmetic: none. Values are passed bit-exact, sign preserved.
- Address: {idx, elem}. Index wrap is impossible because NUM_CODES is a power of two.

Decomposition:
- vq_pkg: DIM, DATA_W, FRAC_BITS=16, NUM_CODES, IDX_W, ELEM_W, and the FSM state enum. Shared with the encoder.
- Sub-module vq_codebook_ram: 1 write port, 1 sync read port, NUM_CODES*DIM x DATA_W.

Test Plan:
- Load code 5 with -1.3125, 4.75, 1.0, 0.5625, -4.625, 3.5, -0.75, -2.6875. Start with idx=5 and ready=1.
  - dout sequence is FFFEB000, 0004C000, 00010000, 00009000, FFFB6000, 00038000, FFFF4000, FFFD5000.
  - This occupies 8 consecutive cycles from T+2, with last_o on the 8th and done_o at T+10.
- Same decode with ready=0 on elements 2 and 6 for 3 cycles each.
  - dout holds 00010000 and FFFF4000 respectively during the stall.
  - No element is lost or duplicated; done_o at T+16.
- Second start_i pulse at T+4 with idx=0.
  - Ignored; the stream stays code 5; a single done_o.
- cb_we_i to {5,3} with data 0 during busy, then decode code 5 again.
  - Element 3 is still 00009000.
  - The same write in IDLE, then decode, returns 00000000.
- Assert rst_i at T+5 mid-stream.
  - valid_o, busy_o, dout_o and done_o go to 0 immediately, with no done_o.
  - After release, a decode of code 5 reproduces the full vector: the codebook is retained.
- Back-to-back decodes of codes 15 then 0, the second start the cycle after done_o.
  - Both streams are correct, addressing the first and last entries.

Source files
------------

// File: rtl/vq_pkg.sv
// rtl/vq_pkg.sv - shared constants and FSM state type for the VQ encoder/decoder pair
package vq_pkg;

   localparam int DIM       = 8;
   localparam int NUM_CODES = 16;
   localparam int DATA_W    = 32;
   localparam int FRAC_BITS = 16;
   localparam int IDX_W     = $clog2(NUM_CODES);
   localparam int ELEM_W    = $clog2(DIM);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } vq_state_e;

endpackage

// File: rtl/vq_codebook_ram.sv
// rtl/vq_codebook_ram.sv - codebook storage, one write port and one synchronous read port
module vq_codebook_ram #(
   parameter int DEPTH  = 128,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port, write-first so a same-edge write to the read address returns the new data.
   always_ff @(posedge clk_i) begin
      if (i_re) begin
         r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vq_decoder.sv
// rtl/vq_decoder.sv - codebook lookup streaming one reconstructed vector per index
module vq_decoder
   import vq_pkg::*;
#(
   parameter int DIM       = vq_pkg::DIM,
   parameter int NUM_CODES = vq_pkg::NUM_CODES,
   parameter int DATA_W    = vq_pkg::DATA_W,
   parameter int IDX_W     = $clog2(NUM_CODES)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cb_we_i,
   input  logic [IDX_W+$clog2(DIM)-1:0] cb_addr_i,
   input  logic [DATA_W-1:0]           cb_data_i,
   input  logic                        start_i,
   input  logic [IDX_W-1:0]            idx_i,
   output logic                        busy_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [DATA_W-1:0]           dout_o,
   output logic [$clog2(DIM)-1:0]      elem_o,
   output logic                        last_o,
   output logic                        done_o
);

   localparam int EW = $clog2(DIM);
   localparam int AW = IDX_W + EW;

   vq_state_e         r_state;
   vq_state_e         w_state_next;
   logic              w_busy;
   logic              w_done;

   logic [IDX_W-1:0]  r_idx;
   logic [EW:0]       r_rd_elem;     // next element to read from the RAM
   logic              r_pend;        // a read was issued last cycle; its data is on w_rdata
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_vld;
   logic [DATA_W-1:0] r_dout;
   logic              r_valid;
   logic [EW-1:0]     r_elem;

   logic              w_start;
   logic              w_xfer;
   logic              w_last;
   logic              w_active;
   logic [1:0]        w_cnt;
   logic              w_issue;
   logic              w_load;
   logic              w_re;
   logic              w_we;
   logic [AW-1:0]     w_raddr;
   logic [DATA_W-1:0] w_rdata;

   assign w_start  = (r_state == ST_IDLE) && start_i;
   assign w_xfer   = r_valid && ready_i;
   assign w_last   = r_valid && (r_elem == EW'(DIM - 1));
   assign w_active = (r_state == ST_FETCH) || (r_state == ST_STREAM);

   // Elements held in dout/hold after this edge; a new read is only issued if its
   // data is guaranteed a slot next cycle even when downstream stalls.
   assign w_cnt   = {1'b0, r_valid} + {1'b0, r_hold_vld} + {1'b0, r_pend} - {1'b0, w_xfer};
   assign w_issue = w_active && (r_rd_elem < (EW + 1)'(DIM)) && (w_cnt < 2'd2);
   assign w_load  = w_active && (!r_valid || w_xfer) && (r_hold_vld || r_pend)
                    && !(w_xfer && w_last);

   assign w_re    = w_start || w_issue;
   assign w_raddr = w_start ? {idx_i, EW'(0)} : {r_idx, r_rd_elem[EW-1:0]};
   assign w_we    = cb_we_i && !w_busy;

   vq_codebook_ram #(
      .DEPTH  (NUM_CODES * DIM),
      .DATA_W (DATA_W),
      .ADDR_W (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .i_we    (w_we),
      .i_waddr (cb_addr_i),
      .i_wdata (cb_data_i),
      .i_re    (w_re),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and state-decoded status outputs.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_busy       = 1'b1;
            w_state_next = ST_STREAM;
         end
         ST_STREAM: begin
            w_busy = 1'b1;
            if (w_xfer && w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Read pointer, prefetch tracking and the one-entry holding register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idx      <= '0;
         r_rd_elem  <= '0;
         r_pend     <= 1'b0;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
      end else if (w_start) begin
         r_idx      <= idx_i;
         r_rd_elem  <= (EW + 1)'(1);
         r_pend     <= 1'b1;
         r_hold_vld <= 1'b0;
      end else begin
         r_pend <= w_issue;
         if (w_issue) begin
            r_rd_elem <= r_rd_elem + (EW + 1)'(1);
         end
         if (w_load && r_hold_vld) begin
            if (r_pend) begin
               r_hold <= w_rdata;
            end else begin
               r_hold_vld <= 1'b0;
            end
         end else if (r_pend && !w_load) begin
            r_hold     <= w_rdata;
            r_hold_vld <= 1'b1;
         end
      end
   end

   // Output element register: loads the oldest buffered element when free or transferring.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_elem  <= '0;
      end else if (w_start) begin
         r_valid <= 1'b0;
      end else if (w_xfer && w_last) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_dout  <= r_hold_vld ? r_hold : w_rdata;
         r_elem  <= (r_state == ST_FETCH) ? EW'(0) : r_elem + EW'(1);
      end else if (w_xfer) begin
         r_valid <= 1'b0;
      end
   end

   assign busy_o  = w_busy;
   assign done_o  = w_done;
   assign valid_o = r_valid;
   assign dout_o  = r_dout;
   assign elem_o  = r_elem;
   assign last_o  = w_last;

endmodule
